// File: rtl/mem_copy_pkg.sv
// Shared sizing defaults and sequencer state encoding for the block copy engine.
package mem_copy_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int MEM_DEPTH  = 32;

  typedef enum logic [1:0] {IDLE, COPY, VERIFY, DONE} copy_state_t;
endpackage

// File: rtl/mem_copy_ctrl.sv
// Address/write-enable sequencer copying a word block from a source memory into
// the destination, with an optional read-back compare pass counting mismatches.
module mem_copy_ctrl
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              verify,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] src_rd,
  input  logic [DATA_W-1:0] dst_rd,
  output logic [ADDR_W-1:0] src_adr,
  output logic [ADDR_W-1:0] dst_adr,
  output logic              dst_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt,
  output logic              err
);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(2**ADDR_W);

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] sb_q, sb_d, db_q, db_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              vfy_q, vfy_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W:0]   len_sat;
  logic              last;

  assign len_sat = (len > LEN_MAX) ? LEN_MAX : len;
  assign last    = ({1'b0, i_q} == (len_q - (ADDR_W+1)'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      sb_q    <= '0;
      db_q    <= '0;
      len_q   <= '0;
      vfy_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      sb_q    <= sb_d;
      db_q    <= db_d;
      len_q   <= len_d;
      vfy_q   <= vfy_d;
      err_q   <= err_d;
    end
  end

  // i is not advanced on the final word so the addresses stay put through DONE/IDLE.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    sb_d    = sb_q;
    db_d    = db_q;
    len_d   = len_q;
    vfy_d   = vfy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = '0;
          if (len_sat != '0) begin
            state_d = COPY;
            i_d     = '0;
            sb_d    = src_base;
            db_d    = dst_base;
            len_d   = len_sat;
            vfy_d   = verify;
          end else begin
            state_d = DONE;
          end
        end
      end
      COPY: begin
        if (last) begin
          if (vfy_q) begin
            state_d = VERIFY;
            i_d     = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          i_d = i_q + ADDR_W'(1);
        end
      end
      VERIFY: begin
        if (src_rd != dst_rd) err_d = err_q + (ADDR_W+1)'(1);
        if (last) state_d = DONE;
        else      i_d     = i_q + ADDR_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign src_adr = sb_q + i_q;
  assign dst_adr = db_q + i_q;
  assign dst_we  = (state_q == COPY);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err_cnt = err_q;
  assign err     = (err_q != '0);
endmodule
